// File: rtl/tpu_pkg.sv
// Shared types and constants for the FP8 x FP8 -> BF16 systolic array blocks.
// Used by the operand feeder and its skew delay lines.
package tpu_pkg;

    typedef logic [7:0]  fp8_t;
    typedef logic [15:0] bf16_t;

    localparam fp8_t FP8_ZERO = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } feeder_state_t;

    // Multiply register plus accumulator update inside each PE.
    localparam int PE_PIPE_LAT = 2;

    // Drain cycles after the last beat: skew of lane N-1, traversal to the far
    // corner PE, the PE pipeline, and one margin cycle.
    function automatic int flush_len(input int n);
        return 2 * (n - 1) + PE_PIPE_LAT + 1;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth register line used to skew one feeder lane (data or clear flag).
// All stages clear to zero on synchronous active-low reset.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                stage_reg[s] <= '0;
            end
        end else begin
            stage_reg[0] <= d;
            for (int s = 1; s < DEPTH; s++) begin
                stage_reg[s] <= stage_reg[s-1];
            end
        end
    end

    assign q = stage_reg[DEPTH-1];

endmodule

// File: rtl/systolic_operand_feeder.sv
// Operand feeder for an N x N FP8 MAC array: skews A/B lanes, generates per-row
// clears, drains with zeros and pulses tile_done. Optional: FEEDER_STALL_CNT_EN.
module systolic_operand_feeder
    import tpu_pkg::*;
#(
    parameter int N     = 4,
    parameter int K_MAX = 256,
    parameter int CNT_W = $clog2(K_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cfg_k,
    input  logic             start,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*8-1:0]   in_a,
    input  logic [N*8-1:0]   in_b,
    output logic [N*8-1:0]   a_edge,
    output logic [N*8-1:0]   b_edge,
    output logic [N-1:0]     clear_a,
    output logic             tile_done
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    localparam int FLUSH_LAST = flush_len(N) - 1;

    feeder_state_t    state_reg, state_next;
    logic [CNT_W-1:0] k_reg;
    logic [CNT_W-1:0] beat_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;
    logic             first_pending_reg;

    logic             start_accept;
    logic             beat_accept;
    logic             last_beat;
    logic             flush_last;
    logic             first_beat;
    logic [CNT_W-1:0] beat_cnt_inc;

    assign in_ready  = (state_reg == FEED);
    assign busy      = (state_reg == FEED) || (state_reg == FLUSH);
    assign tile_done = (state_reg == DONE);

    assign start_accept = (state_reg == IDLE) && start && (cfg_k != '0);
    assign beat_accept  = in_ready && in_valid;
    assign beat_cnt_inc = beat_cnt_reg + CNT_W'(1);
    assign last_beat    = (beat_cnt_inc == k_reg);
    assign flush_last   = (flush_cnt_reg == CNT_W'(FLUSH_LAST));
    // Flag held pending until a real beat arrives, so bubbles before the first
    // beat never produce a clear on zero data.
    assign first_beat   = beat_accept && first_pending_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_accept)             state_next = FEED;
            FEED:    if (beat_accept && last_beat) state_next = FLUSH;
            FLUSH:   if (flush_last)               state_next = DONE;
            DONE:                                  state_next = IDLE;
            default:                               state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            k_reg             <= '0;
            beat_cnt_reg      <= '0;
            flush_cnt_reg     <= '0;
            first_pending_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (start_accept) begin
                k_reg             <= cfg_k;
                beat_cnt_reg      <= '0;
                first_pending_reg <= 1'b1;
            end
            if (beat_accept) begin
                first_pending_reg <= 1'b0;
                if (beat_cnt_reg < k_reg) begin
                    beat_cnt_reg <= beat_cnt_inc;
                end
            end
            if (state_reg == FEED) begin
                flush_cnt_reg <= '0;
            end else if ((state_reg == FLUSH) && !flush_last) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
            end
        end
    end

`ifdef FEEDER_STALL_CNT_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (start_accept) begin
            stall_cnt_reg <= '0;
        end else if ((state_reg == FEED) && !in_valid && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

    // Lane i: data needs i+1 stages, the clear flag one more to line up with
    // the product leaving the PE multiply register.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            fp8_t        lane_a, lane_b;
            logic [15:0] lane_q;
            logic        clear_q;

            assign lane_a = beat_accept ? fp8_t'(in_a[gi*8 +: 8]) : FP8_ZERO;
            assign lane_b = beat_accept ? fp8_t'(in_b[gi*8 +: 8]) : FP8_ZERO;

            skew_delay_line #(
                .DEPTH(gi + 1),
                .WIDTH(16)
            ) u_data_line (
                .clk  (clk),
                .rst_n(rst_n),
                .d    ({lane_a, lane_b}),
                .q    (lane_q)
            );

            skew_delay_line #(
                .DEPTH(gi + 2),
                .WIDTH(1)
            ) u_clear_line (
                .clk  (clk),
                .rst_n(rst_n),
                .d    (first_beat),
                .q    (clear_q)
            );

            assign a_edge[gi*8 +: 8] = lane_q[15:8];
            assign b_edge[gi*8 +: 8] = lane_q[7:0];
            assign clear_a[gi]       = clear_q;
        end
    endgenerate

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Directed self-checking bench for systolic_operand_feeder (N=4).
// Define FEEDER_STALL_CNT_EN to also exercise the stall counter.
module tb_systolic_operand_feeder;

    localparam int N     = 4;
    localparam int CNT_W = 9;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CNT_W-1:0] cfg_k;
    logic             start;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [N*8-1:0]   in_a;
    logic [N*8-1:0]   in_b;
    logic [N*8-1:0]   a_edge;
    logic [N*8-1:0]   b_edge;
    logic [N-1:0]     clear_a;
    logic             tile_done;
`ifdef FEEDER_STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    systolic_operand_feeder #(.N(N), .K_MAX(256), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_k    (cfg_k),
        .start    (start),
        .busy     (busy),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .a_edge   (a_edge),
        .b_edge   (b_edge),
        .clear_a  (clear_a),
        .tile_done(tile_done)
`ifdef FEEDER_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Beat j of a tile, lane i: A = 0x30+4j+i, B = 0x40+4j+i.
    task automatic drive_beat(input int bi);
        in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            in_a[i*8 +: 8] = 8'h30 + 8'(4 * bi + i);
            in_b[i*8 +: 8] = 8'h40 + 8'(4 * bi + i);
        end
    endtask

    task automatic drive_idle();
        in_valid = 1'b0;
        in_a     = '1;
        in_b     = '1;
    endtask

    // Expected edges at cycle c given the cycles at which beats were accepted.
    function automatic void exp_lanes(input int c, input int acc[8], input int nacc, input int kt,
                                      output logic [31:0] ea, output logic [31:0] eb,
                                      output logic [3:0] ec);
        ea = '0;
        eb = '0;
        ec = '0;
        for (int j = 0; j < nacc; j++) begin
            for (int i = 0; i < N; i++) begin
                if (c == acc[j] + 1 + i) begin
                    ea[i*8 +: 8] = 8'h30 + 8'(4 * (j % kt) + i);
                    eb[i*8 +: 8] = 8'h40 + 8'(4 * (j % kt) + i);
                end
                if ((j % kt) == 0 && c == acc[j] + 2 + i) ec[i] = 1'b1;
            end
        end
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; cfg_k = 9'd3;
        drive_beat(0);
        step(); step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        checks++; if (a_edge !== 32'h0 || b_edge !== 32'h0) begin errors++; $display("FAIL reset_edges got %h/%h exp 0", a_edge, b_edge); end
        checks++; if (clear_a !== 4'h0 || tile_done !== 1'b0) begin errors++; $display("FAIL reset_flags got clear %b done %b exp 0", clear_a, tile_done); end
        rst_n = 1'b1; start = 1'b0; cfg_k = '0;
        drive_idle();
        step();
        $display("test_reset done");
    endtask

    task automatic test_feed_k3();
        int acc[8]; int nacc = 0;
        logic [31:0] ea, eb; logic [3:0] ec;
        cfg_k = 9'd3; start = 1'b1;
        step();
        start = 1'b0; cfg_k = '0;
        for (int c = 1; c <= 16; c++) begin
            exp_lanes(c, acc, nacc, 3, ea, eb, ec);
            checks++; if (a_edge !== ea) begin errors++; $display("FAIL k3_a_edge c%0d got %h exp %h", c, a_edge, ea); end
            checks++; if (b_edge !== eb) begin errors++; $display("FAIL k3_b_edge c%0d got %h exp %h", c, b_edge, eb); end
            checks++; if (clear_a !== ec) begin errors++; $display("FAIL k3_clear c%0d got %b exp %b", c, clear_a, ec); end
            checks++; if (tile_done !== (c == 13)) begin errors++; $display("FAIL k3_done c%0d got %b exp %b", c, tile_done, c == 13); end
            checks++; if (busy !== (c <= 12)) begin errors++; $display("FAIL k3_busy c%0d got %b exp %b", c, busy, c <= 12); end
            checks++; if (in_ready !== (c <= 3)) begin errors++; $display("FAIL k3_ready c%0d got %b exp %b", c, in_ready, c <= 3); end
            if (c <= 3) begin
                drive_beat(nacc);
                acc[nacc] = c; nacc++;
            end else begin
                drive_idle();
            end
            step();
        end
        $display("test_feed_k3 done");
    endtask

    task automatic test_bubbles();
        int acc[8]; int nacc = 0;
        logic [31:0] ea, eb; logic [3:0] ec;
        cfg_k = 9'd2; start = 1'b1;
        step();
        start = 1'b0; cfg_k = '0;
        // Stall at c1 before the first beat, then 3 stalls between beats.
        for (int c = 1; c <= 19; c++) begin
            exp_lanes(c, acc, nacc, 2, ea, eb, ec);
            checks++; if (a_edge !== ea) begin errors++; $display("FAIL bub_a_edge c%0d got %h exp %h", c, a_edge, ea); end
            checks++; if (b_edge !== eb) begin errors++; $display("FAIL bub_b_edge c%0d got %h exp %h", c, b_edge, eb); end
            checks++; if (clear_a !== ec) begin errors++; $display("FAIL bub_clear c%0d got %b exp %b", c, clear_a, ec); end
            checks++; if (tile_done !== (c == 16)) begin errors++; $display("FAIL bub_done c%0d got %b exp %b", c, tile_done, c == 16); end
            checks++; if (in_ready !== (c <= 6)) begin errors++; $display("FAIL bub_ready c%0d got %b exp %b", c, in_ready, c <= 6); end
            if (c == 2 || c == 6) begin
                drive_beat(nacc);
                acc[nacc] = c; nacc++;
            end else begin
                drive_idle();
            end
            step();
        end
`ifdef FEEDER_STALL_CNT_EN
        checks++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL bub_stall_cnt got %0d exp 4", stall_cnt); end
`endif
        $display("test_bubbles done");
    endtask

    task automatic test_ignore_zero_k();
        cfg_k = 9'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL zero_k c%0d got busy %b ready %b exp 0 0", c, busy, in_ready); end
            step();
        end
        $display("test_ignore_zero_k done");
    endtask

    task automatic test_start_in_flush();
        int dones = 0;
        cfg_k = 9'd1; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            if (tile_done) dones++;
            checks++; if (tile_done !== (c == 11)) begin errors++; $display("FAIL sif_done c%0d got %b exp %b", c, tile_done, c == 11); end
            checks++; if (busy !== (c <= 10)) begin errors++; $display("FAIL sif_busy c%0d got %b exp %b", c, busy, c <= 10); end
            checks++; if (in_ready !== (c == 1)) begin errors++; $display("FAIL sif_ready c%0d got %b exp %b", c, in_ready, c == 1); end
            if (c == 1) drive_beat(0); else drive_idle();
            start = (c >= 4 && c <= 6);
            cfg_k = (c >= 4 && c <= 6) ? 9'd5 : 9'd0;
            step();
        end
        checks++; if (dones != 1) begin errors++; $display("FAIL sif_done_count got %0d exp 1", dones); end
        $display("test_start_in_flush done");
    endtask

    task automatic test_back_to_back();
        int acc[8]; int nacc = 0; int dones = 0;
        logic [31:0] ea, eb; logic [3:0] ec;
        logic exp_busy, exp_ready;
        cfg_k = 9'd2; start = 1'b1;
        step();
        for (int c = 1; c <= 28; c++) begin
            exp_lanes(c, acc, nacc, 2, ea, eb, ec);
            exp_busy  = (c <= 11) || (c >= 14 && c <= 24);
            exp_ready = (c <= 2) || (c == 14) || (c == 15);
            if (tile_done) dones++;
`ifdef FEEDER_STALL_CNT_EN
            if (c == 1) begin
                checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL b2b_stall_clear got %0d exp 0", stall_cnt); end
            end
`endif
            checks++; if (a_edge !== ea) begin errors++; $display("FAIL b2b_a_edge c%0d got %h exp %h", c, a_edge, ea); end
            checks++; if (clear_a !== ec) begin errors++; $display("FAIL b2b_clear c%0d got %b exp %b", c, clear_a, ec); end
            checks++; if (tile_done !== (c == 12 || c == 25)) begin errors++; $display("FAIL b2b_done c%0d got %b exp %b", c, tile_done, c == 12 || c == 25); end
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL b2b_busy c%0d got %b exp %b", c, busy, exp_busy); end
            checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL b2b_ready c%0d got %b exp %b", c, in_ready, exp_ready); end
            start = (c <= 13);
            if (exp_ready) begin
                drive_beat(nacc % 2);
                acc[nacc] = c; nacc++;
            end else if (c == 13) begin
                in_valid = 1'b1; in_a = '1; in_b = '1;
            end else begin
                drive_idle();
            end
            step();
        end
        start = 1'b0; cfg_k = '0;
        checks++; if (dones != 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", dones); end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid_tile();
        cfg_k = 9'd8; start = 1'b1;
        step();
        start = 1'b0; cfg_k = '0;
        for (int c = 1; c <= 3; c++) begin
            drive_beat(c - 1);
            step();
        end
        rst_n = 1'b0;
        step();
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_state got busy %b ready %b exp 0 0", busy, in_ready); end
        checks++; if (a_edge !== 32'h0 || b_edge !== 32'h0) begin errors++; $display("FAIL rst_mid_edges got %h/%h exp 0", a_edge, b_edge); end
        checks++; if (clear_a !== 4'h0) begin errors++; $display("FAIL rst_mid_clear got %b exp 0", clear_a); end
        rst_n = 1'b1;
        drive_idle();
        for (int c = 0; c < 20; c++) begin
            checks++; if (tile_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_after c%0d got done %b busy %b exp 0 0", c, tile_done, busy); end
            step();
        end
        $display("test_reset_mid_tile done");
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_k = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0;
        test_reset();
        test_feed_k3();
        test_bubbles();
        test_ignore_zero_k();
        test_start_in_flush();
        test_back_to_back();
        test_reset_mid_tile();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
